spi_regf_bridge: RTL and testbench

- Sits directly downstream of the SPI slave shift engine and upstream of the control register file's internal port.
- Parses word-level SPI frames into register-file accesses: a header word (read/write, auto-increment, address) followed by data words.
- Writes go to the register file; read data is fetched and handed back to the slave's transmit buffer one word ahead of the master's clocking.
- Single clock domain; all inputs from the SPI slave are already synchronised to clk.

---
 rtl/spi_regf_bridge_pkg.sv | 19 +
 rtl/spi_hdr_decode.sv | 26 ++
 rtl/spi_regf_bridge.sv | 163 ++++++++++++++++
 tb/tb_spi_regf_bridge.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regf_bridge_pkg.sv
// Shared definitions for the SPI-to-register-file bridge: default widths,
// header bit positions and FSM state encoding.
package spi_regf_bridge_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 6;
  localparam int HDR_RNW_BIT  = DATA_W_DEF - 1;
  localparam int HDR_AINC_BIT = DATA_W_DEF - 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR      = 3'd1,
    ST_WR       = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_CAPT  = 3'd4,
    ST_RD_WAIT  = 3'd5
  } state_e;

endpackage

// File: rtl/spi_hdr_decode.sv
// Splits an SPI header word into read/write flag, auto-increment flag and
// start address.
module spi_hdr_decode
  import spi_regf_bridge_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [DATA_W-1:0] hdr_i,
  output logic              rnw_o,
  output logic              ainc_o,
  output logic [ADDR_W-1:0] addr_o
);

  // Flag positions track the top of the word when DATA_W differs from default.
  localparam int RNW_POS  = HDR_RNW_BIT + DATA_W - DATA_W_DEF;
  localparam int AINC_POS = HDR_AINC_BIT + DATA_W - DATA_W_DEF;

  logic unused_hdr_bits;

  assign rnw_o           = hdr_i[RNW_POS];
  assign ainc_o          = hdr_i[AINC_POS];
  assign addr_o          = hdr_i[ADDR_W-1:0];
  assign unused_hdr_bits = ^hdr_i[DATA_W-3:ADDR_W];

endmodule

// File: rtl/spi_regf_bridge.sv
// Turns word-level SPI frames (header + data words) into register-file
// accesses and feeds read data back to the slave transmit buffer.
//
// state       | meaning
// ST_IDLE     | no frame; waiting for frame_active rising
// ST_HDR      | frame open, waiting for header word
// ST_WR       | write burst, one register write per received word
// ST_RD_ISSUE | read request on the register-file port
// ST_RD_CAPT  | read data returned; load it into the transmit buffer
// ST_RD_WAIT  | waiting for the master to clock out the loaded word
module spi_regf_bridge
  import spi_regf_bridge_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_active,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_load,
  output logic              int_req,
  output logic              int_rnw,
  output logic [ADDR_W-1:0] int_addr,
  output logic [DATA_W-1:0] int_data_in,
  input  logic [DATA_W-1:0] int_data_out,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  state_e              state_q, state_d;
  logic                fa_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ainc_q, ainc_d;
  logic                wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_load_q, tx_load_d;
  logic                err_q, err_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                hdr_rnw, hdr_ainc;
  logic [ADDR_W-1:0]   hdr_addr;
  logic                frame_rise, frame_end;

  spi_hdr_decode #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_hdr_decode (
    .hdr_i  (rx_data),
    .rnw_o  (hdr_rnw),
    .ainc_o (hdr_ainc),
    .addr_o (hdr_addr)
  );

  assign frame_rise = frame_active && !fa_q;
  assign frame_end  = (state_q != ST_IDLE) && !frame_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fa_q      <= 1'b0;
      addr_q    <= '0;
      ainc_q    <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      tx_load_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      fa_q      <= frame_active;
      addr_q    <= addr_d;
      ainc_q    <= ainc_d;
      wr_pend_q <= wr_pend_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      tx_load_q <= tx_load_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (frame_rise) state_d = ST_HDR;
      ST_HDR:      if (rx_valid) state_d = hdr_rnw ? ST_RD_ISSUE : ST_WR;
      ST_WR:       state_d = ST_WR;
      ST_RD_ISSUE: state_d = ST_RD_CAPT;
      ST_RD_CAPT:  state_d = ST_RD_WAIT;
      ST_RD_WAIT:  if (rx_valid) state_d = ST_RD_ISSUE;
      default:     state_d = ST_IDLE;
    endcase
    // A word arriving with the frame end is still handled above first.
    if (frame_end) state_d = ST_IDLE;
  end

  always_comb begin
    addr_d    = addr_q;
    ainc_d    = ainc_q;
    wr_pend_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    tx_load_d = 1'b0;
    err_d     = err_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: if (frame_rise) err_d = 1'b0;
      ST_HDR: begin
        if (rx_valid) begin
          addr_d = hdr_addr;
          ainc_d = hdr_ainc;
        end else if (frame_end) begin
          err_d = 1'b1;
        end
      end
      ST_WR: begin
        if (rx_valid) begin
          wr_pend_d = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = rx_data;
          addr_d    = addr_q + ADDR_W'(ainc_q);
        end
      end
      ST_RD_ISSUE: if (rx_valid) err_d = 1'b1;
      ST_RD_CAPT: begin
        if (rx_valid) err_d = 1'b1;
        if (frame_active) begin
          tx_data_d = int_data_out;
          tx_load_d = 1'b1;
          addr_d    = addr_q + ADDR_W'(ainc_q);
        end
      end
      default: ;
    endcase
    if (frame_end) cnt_d = cnt_q + 16'd1;
  end

  // A pending write and a read issue can never share a cycle: a write only
  // leaves WR through IDLE, which is at least two cycles from RD_ISSUE.
  always_comb begin
    int_req     = wr_pend_q || (state_q == ST_RD_ISSUE);
    int_rnw     = (state_q == ST_RD_ISSUE);
    int_addr    = '0;
    int_data_in = '0;
    if (state_q == ST_RD_ISSUE) begin
      int_addr = addr_q;
    end else if (wr_pend_q) begin
      int_addr    = wr_addr_q;
      int_data_in = wr_data_q;
    end
    tx_data   = tx_data_q;
    tx_load   = tx_load_q;
    frame_err = err_q;
    frame_cnt = cnt_q;
  end

endmodule

// File: tb/tb_spi_regf_bridge.sv
// Scoreboard bench for spi_regf_bridge: directed frames push expected
// register accesses and transmit loads; a monitor checks them as they appear.
module tb_spi_regf_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_active = 1'b0;
  logic        rx_valid = 1'b0;
  logic [31:0] rx_data = '0;
  logic [31:0] tx_data;
  logic        tx_load;
  logic        int_req;
  logic        int_rnw;
  logic [5:0]  int_addr;
  logic [31:0] int_data_in;
  logic [31:0] int_data_out = '0;
  logic        frame_err;
  logic [15:0] frame_cnt;

  typedef struct {
    logic        rnw;
    logic [5:0]  addr;
    logic [31:0] data;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_tx[$];
  logic [31:0] mem [64];
  int          n_tests = 0;
  int          n_fail  = 0;

  spi_regf_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .frame_active (frame_active),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_data      (tx_data),
    .tx_load      (tx_load),
    .int_req      (int_req),
    .int_rnw      (int_rnw),
    .int_addr     (int_addr),
    .int_data_in  (int_data_in),
    .int_data_out (int_data_out),
    .frame_err    (frame_err),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  // Register-file model: read data returns the cycle after the request.
  always @(posedge clk) begin
    if (int_req) begin
      if (int_rnw) int_data_out <= mem[int_addr];
      else         mem[int_addr] <= int_data_in;
    end
  end

  // Monitor: every request or transmit load must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (int_req) begin
        n_tests++;
        if (exp_req.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_req: got rnw=%0d addr=%0h data=%0h, required no request",
                   int_rnw, int_addr, int_data_in);
        end else begin
          req_t e;
          e = exp_req.pop_front();
          if (int_rnw !== e.rnw || int_addr !== e.addr || (!e.rnw && int_data_in !== e.data)) begin
            n_fail++;
            $display("FAIL req: got rnw=%0d addr=%0h data=%0h, required rnw=%0d addr=%0h data=%0h",
                     int_rnw, int_addr, int_data_in, e.rnw, e.addr, e.data);
          end
        end
      end
      if (tx_load) begin
        n_tests++;
        if (exp_tx.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_tx_load: got tx_data=%0h, required no load", tx_data);
        end else begin
          logic [31:0] t;
          t = exp_tx.pop_front();
          if (tx_data !== t) begin
            n_fail++;
            $display("FAIL tx_load: got tx_data=%0h, required %0h", tx_data, t);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [5:0] a, input logic [31:0] d);
    req_t r;
    r.rnw = 1'b0; r.addr = a; r.data = d;
    exp_req.push_back(r);
  endtask

  task automatic push_rd(input logic [5:0] a, input logic [31:0] d);
    req_t r;
    r.rnw = 1'b1; r.addr = a; r.data = '0;
    exp_req.push_back(r);
    exp_tx.push_back(d);
  endtask

  task automatic frame_start();
    frame_active = 1'b1;
    tick();
  endtask

  task automatic frame_stop();
    frame_active = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    rx_valid = 1'b1;
    rx_data  = w;
    tick();
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_data", tx_data, 32'h0);
    chk("reset_strobes", {29'b0, tx_load, int_req, int_rnw}, 32'h0);
    chk("reset_int_addr", {26'b0, int_addr}, 32'h0);
    chk("reset_frame_cnt", {16'b0, frame_cnt}, 32'h0);
    chk("reset_frame_err", {31'b0, frame_err}, 32'h0);
    rst = 1'b0;
    tick();

    // Write burst with auto-increment
    push_wr(6'h05, 32'h11); push_wr(6'h06, 32'h22); push_wr(6'h07, 32'h33);
    frame_start();
    send_word(32'h4000_0005);
    send_word(32'h11); send_word(32'h22); send_word(32'h33);
    frame_stop();
    chk("burst_frame_cnt", {16'b0, frame_cnt}, 32'd1);
    chk("burst_frame_err", {31'b0, frame_err}, 32'd0);

    // Seed register 9, then read it three times without auto-increment
    push_wr(6'h09, 32'hDEAD_BEEF);
    frame_start();
    send_word(32'h0000_0009);
    send_word(32'hDEAD_BEEF);
    frame_stop();
    push_rd(6'h09, 32'hDEAD_BEEF); push_rd(6'h09, 32'hDEAD_BEEF); push_rd(6'h09, 32'hDEAD_BEEF);
    frame_start();
    send_word(32'h8000_0009);
    send_word(32'h0); send_word(32'h0);
    frame_stop();
    chk("read_frame_cnt", {16'b0, frame_cnt}, 32'd3);
    chk("read_frame_err", {31'b0, frame_err}, 32'd0);

    // Address wrap on writes, then on auto-increment reads
    push_wr(6'h3E, 32'hA1); push_wr(6'h3F, 32'hB2); push_wr(6'h00, 32'hC3);
    frame_start();
    send_word(32'h4000_003E);
    send_word(32'hA1); send_word(32'hB2); send_word(32'hC3);
    frame_stop();
    push_rd(6'h3F, 32'hB2); push_rd(6'h00, 32'hC3);
    frame_start();
    send_word(32'hC000_003F);
    send_word(32'h0);
    frame_stop();
    chk("wrap_frame_cnt", {16'b0, frame_cnt}, 32'd5);

    // Overrun: a word during RD_CAPT is dropped, the load still happens
    push_rd(6'h09, 32'hDEAD_BEEF);
    frame_start();
    rx_valid = 1'b1; rx_data = 32'h8000_0009;
    tick();
    rx_valid = 1'b0;
    tick();
    rx_valid = 1'b1; rx_data = 32'h1234_5678;
    tick();
    rx_valid = 1'b0; rx_data = '0;
    repeat (4) tick();
    chk("overrun_err_set", {31'b0, frame_err}, 32'd1);
    frame_stop();
    chk("overrun_err_sticky", {31'b0, frame_err}, 32'd1);
    chk("overrun_frame_cnt", {16'b0, frame_cnt}, 32'd6);

    // Abort while in RD_CAPT: request already issued, no load afterwards
    push_wr(6'h00, 32'h0);
    exp_req.pop_back();
    begin
      req_t r;
      r.rnw = 1'b1; r.addr = 6'h09; r.data = '0;
      exp_req.push_back(r);
    end
    frame_start();
    chk("frame_start_clears_err", {31'b0, frame_err}, 32'd0);
    rx_valid = 1'b1; rx_data = 32'h8000_0009;
    tick();
    rx_valid = 1'b0; rx_data = '0;
    tick();
    frame_active = 1'b0;
    repeat (6) tick();
    chk("abort_frame_cnt", {16'b0, frame_cnt}, 32'd7);
    chk("abort_frame_err", {31'b0, frame_err}, 32'd0);

    // Empty frame: counted and flagged
    frame_start();
    frame_stop();
    chk("empty_frame_err", {31'b0, frame_err}, 32'd1);
    chk("empty_frame_cnt", {16'b0, frame_cnt}, 32'd8);

    // Reset in the middle of a write burst
    push_wr(6'h10, 32'h55);
    frame_start();
    send_word(32'h4000_0010);
    send_word(32'h55);
    rst = 1'b1;
    #1;
    chk("midrst_tx_data", tx_data, 32'h0);
    chk("midrst_strobes", {29'b0, tx_load, int_req, int_rnw}, 32'h0);
    chk("midrst_frame_cnt", {16'b0, frame_cnt}, 32'h0);
    chk("midrst_frame_err", {31'b0, frame_err}, 32'h0);
    repeat (2) tick();
    frame_active = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    push_wr(6'h05, 32'h77); push_wr(6'h06, 32'h88);
    frame_start();
    send_word(32'h4000_0005);
    send_word(32'h77); send_word(32'h88);
    frame_stop();
    chk("post_rst_frame_cnt", {16'b0, frame_cnt}, 32'd1);
    chk("post_rst_frame_err", {31'b0, frame_err}, 32'd0);

    repeat (4) tick();
    chk("req_queue_drained", exp_req.size(), 32'd0);
    chk("tx_queue_drained", exp_tx.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
